txrx_link_scheduler: RTL and testbench
======================================

# txrx_link_scheduler

Single-clock controller that shares the RX→TX byte path among `N_REQ` requesters and sequences each transfer. It grants one requester round-robin, drives the byte and a one-cycle capture enable into the RX stage, waits for the RX latch acknowledge, then holds the synthesizer enable for a fixed tone window. A mandatory inter-frame gap follows each transfer. It sits between the requesting clients and the TX/RX/synthesizer datapath.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `HOLD_CYCLES`, default 16: cycles `synth_en` stays high per transfer, ≥1.
- `GAP_CYCLES`, default 2: idle cycles after each transfer, ≥0.
- `LATCH_TIMEOUT`, default 8: max cycles to wait for `latch_enable`, ≥1.

- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in N_REQ: per-requester request; held until granted.
- `req_data` in 8*N_REQ: byte of requester i at bits [8i+7:8i], stable while `req[i]`.
- `gnt` out N_REQ: one-hot, one-cycle acceptance pulse.
- `rx_data` out 8: byte to RX `in_data`.
- `rx_en` out 1: one-cycle capture strobe to RX `en_Rx`.
- `latch_enable` in 1: acknowledge from RX stage.
- `synth_en` out 1: synthesizer/TX enable window.
- `owner` out $clog2(N_REQ): index of current/last granted requester.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: one-cycle pulse on latch timeout.

## Operation
- States: IDLE, CAPTURE, WAIT_LATCH, HOLD, GAP. All outputs are registered.
- IDLE: if any `req` is high, pick the first requester at or after `rr_ptr` (wrap modulo N_REQ). Next cycle enter CAPTURE with `gnt[w]=1`, `rx_en=1`, `rx_data=req_data[w]`, `owner=w`, and `rr_ptr=(w+1) mod N_REQ`.
- CAPTURE: lasts exactly 1 cycle. Then WAIT_LATCH with the counter cleared. `gnt` and `rx_en` return to 0.
- WAIT_LATCH:
  - If `latch_enable` is sampled 1, go to HOLD with `synth_en=1`.
  - Otherwise increment the counter. When it reaches LATCH_TIMEOUT, pulse `timeout_err` and go to GAP (no HOLD).
  - `latch_enable` seen in any other state is ignored.
- HOLD: `synth_en=1` for exactly HOLD_CYCLES cycles, then GAP.
- GAP: GAP_CYCLES cycles, then IDLE. If GAP_CYCLES=0, go HOLD/timeout→IDLE directly.
- `rx_data` and `owner` hold their values until the next grant.
- Requests arriving while busy wait; no queueing beyond the `req` level.
- A requester that drops `req` before its grant is simply not granted.
- Counter width is $clog2(max(HOLD_CYCLES, GAP_CYCLES, LATCH_TIMEOUT)+1). It is cleared on every state entry and never wraps.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `gnt=0`, `rx_en=0`, `rx_data=0`, `synth_en=0`, `owner=0`, `busy=0`, `timeout_err=0`.
- `rst` mid-transfer aborts at the next edge to the reset values; no `timeout_err` is issued.
- Latency from `req` high in IDLE (edge N) to `gnt`/`rx_en` high: 1 cycle (visible after edge N+1).
- With an RX ack one cycle after `rx_en`, the minimum transfer is 1 (CAPTURE) + 1 (WAIT) + HOLD_CYCLES + GAP_CYCLES cycles from grant to IDLE.
- A timeout transfer occupies 1 + LATCH_TIMEOUT + GAP_CYCLES cycles.
- `latch_enable` high in the same cycle the counter hits LATCH_TIMEOUT: the ack wins and the transfer goes to HOLD.
- A request in the first IDLE cycle after GAP is granted; the scheduler is never forced to idle an extra cycle.

## Structure
- Shared package `txrx_pkg`: state enum `sched_state_t` (IDLE, CAPTURE, WAIT_LATCH, HOLD, GAP) and the byte-width constant `TXRX_DW=8`.
- One sub-module, `rr_arbiter`: parameterized on N_REQ. Takes `req` and `rr_ptr`, returns combinational one-hot `win` and index plus a `valid`. The scheduler FSM and counter stay in the top.

## Test plan
- Reset and single request: hold `rst` for 2 cycles. Then `req=4'b0100`, `req_data[23:16]=8'hA5`, RX acks 1 cycle after `rx_en`.
  - Expect `gnt=4'b0100` and `rx_en` for 1 cycle, `rx_data=8'hA5`, `owner=2`.
  - Then `synth_en` high for 16 cycles and `busy` low after 2 GAP cycles.
- Round-robin: hold `req=4'b1111` continuously. Expect grant order 0, 1, 2, 3, 0, with `rx_data` matching each requester's byte.
- Latch timeout: never assert `latch_enable`. Expect `timeout_err` as a single pulse 8 cycles after CAPTURE, `synth_en` never high, return to IDLE after 2 GAP cycles.
- Ack/timeout collision: assert `latch_enable` exactly in the 8th WAIT_LATCH cycle. Expect HOLD entered and no `timeout_err`.
- Reset mid-HOLD: pulse `rst` for 1 cycle at HOLD cycle 5. Expect `synth_en=0`, `busy=0`, `rr_ptr=0` next cycle, and a pending `req=4'b0010` granted 1 cycle after `rst` falls.
- GAP_CYCLES=0 build: back-to-back requests. Expect the next `gnt` exactly 1 cycle after `synth_en` falls.

Source files
------------

// File: rtl/txrx_link_scheduler_pkg.sv
// Shared types and constants for the TX/RX link scheduler.
package txrx_pkg;

  localparam int unsigned TXRX_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WAIT_LATCH,
    HOLD,
    GAP
  } sched_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/txrx_link_scheduler_if.sv
// Requester / RX-stage bus of the link scheduler.
interface txrx_link_scheduler_if #(
  parameter int unsigned N_REQ = 4
);
  import txrx_pkg::*;

  localparam int unsigned IW = $clog2(N_REQ);

  logic [N_REQ-1:0]         req;
  logic [TXRX_DW*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]         gnt;
  logic [TXRX_DW-1:0]       rx_data;
  logic                     rx_en;
  logic                     latch_enable;
  logic                     synth_en;
  logic [IW-1:0]            owner;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    output req, req_data, latch_enable,
    input  gnt, rx_data, rx_en, synth_en, owner, busy, timeout_err
  );

  modport slave (
    input  req, req_data, latch_enable,
    output gnt, rx_data, rx_en, synth_en, owner, busy, timeout_err
  );

endinterface

// File: rtl/txrx_link_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         win,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     valid
);

  localparam int unsigned IW = $clog2(N_REQ);

  // Scan N_REQ slots starting at rr_ptr, wrapping once.
  always_comb begin
    int unsigned j;
    j     = 0;
    win   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = 32'(rr_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        win[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/txrx_link_scheduler.sv
// Round-robin scheduler sequencing capture, latch wait, tone hold and gap.
module txrx_link_scheduler
  import txrx_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned LATCH_TIMEOUT = 8
) (
  input logic                  clk,
  input logic                  rst,
  txrx_link_scheduler_if.slave bus
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, LATCH_TIMEOUT) + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] T_LAST    = CW'(LATCH_TIMEOUT - 1);
  // With no gap the transfer returns straight to IDLE.
  localparam sched_state_t AFTER_XFER = (GAP_CYCLES == 0) ? IDLE : GAP;

  sched_state_t state, state_n;
  logic [CW-1:0]      cnt, cnt_d;
  logic [IW-1:0]      rr_ptr, rr_ptr_d;
  logic [N_REQ-1:0]   win, gnt_d;
  logic [IW-1:0]      win_idx, owner_d;
  logic               win_valid, rx_en_d, synth_en_d, busy_d, timeout_d;
  logic [TXRX_DW-1:0] rx_data_d;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .win    (win),
    .idx    (win_idx),
    .valid  (win_valid)
  );

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      rr_ptr          <= '0;
      bus.gnt         <= '0;
      bus.rx_en       <= 1'b0;
      bus.rx_data     <= '0;
      bus.synth_en    <= 1'b0;
      bus.owner       <= '0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_d;
      rr_ptr          <= rr_ptr_d;
      bus.gnt         <= gnt_d;
      bus.rx_en       <= rx_en_d;
      bus.rx_data     <= rx_data_d;
      bus.synth_en    <= synth_en_d;
      bus.owner       <= owner_d;
      bus.busy        <= busy_d;
      bus.timeout_err <= timeout_d;
    end
  end

  // Next-state selection; ack beats timeout in the last wait cycle.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       if (win_valid) state_n = CAPTURE;
      CAPTURE:    state_n = WAIT_LATCH;
      WAIT_LATCH: begin
        if (bus.latch_enable)   state_n = HOLD;
        else if (cnt == T_LAST) state_n = AFTER_XFER;
      end
      HOLD:       if (cnt == HOLD_LAST) state_n = AFTER_XFER;
      GAP:        if (cnt == GAP_LAST)  state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and round-robin pointer.
  always_comb begin
    gnt_d      = '0;
    rx_en_d    = 1'b0;
    rx_data_d  = bus.rx_data;
    owner_d    = bus.owner;
    rr_ptr_d   = rr_ptr;
    timeout_d  = 1'b0;
    synth_en_d = (state_n == HOLD);
    busy_d     = (state_n != IDLE);
    // Counter restarts on every state change and only runs in timed states.
    if (state_n != state)                      cnt_d = '0;
    else if (state == IDLE || state == CAPTURE) cnt_d = cnt;
    else                                        cnt_d = cnt + CW'(1);

    if (state == IDLE && win_valid) begin
      gnt_d    = win;
      rx_en_d  = 1'b1;
      owner_d  = win_idx;
      rr_ptr_d = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
      for (int unsigned i = 0; i < N_REQ; i++)
        if (win[i]) rx_data_d = bus.req_data[i*TXRX_DW +: TXRX_DW];
    end
    if (state == WAIT_LATCH && !bus.latch_enable && cnt == T_LAST) timeout_d = 1'b1;
  end

endmodule

// File: tb/tb_txrx_link_scheduler.sv
// Self-checking bench for txrx_link_scheduler with a transfer-timeline model.
module tb_txrx_link_scheduler;
  import txrx_pkg::*;

  localparam int N = 4;
  localparam int H = 16;
  localparam int G = 2;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  txrx_link_scheduler_if #(.N_REQ(N)) ifc ();
  txrx_link_scheduler_if #(.N_REQ(N)) ifc0 ();

  txrx_link_scheduler #(
    .N_REQ(N), .HOLD_CYCLES(H), .GAP_CYCLES(G), .LATCH_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  txrx_link_scheduler #(
    .N_REQ(N), .HOLD_CYCLES(H), .GAP_CYCLES(0), .LATCH_TIMEOUT(T)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(ifc0)
  );

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  function automatic int pick(input logic [3:0] mask, input int ptr);
    for (int i = 0; i < N; i++)
      if (mask[(ptr + i) % N]) return (ptr + i) % N;
    return 0;
  endfunction

  // One transfer from an IDLE negedge: request, grant, then the full timeline.
  // d in 1..T = ack in WAIT cycle d; anything else = no ack (timeout).
  task automatic xfer(input logic [3:0] mask, input bit keep, input int d, input bit noise,
                      input logic [31:0] data, input int abort_t, input logic [3:0] abort_req,
                      input string name);
    int w, last, wait_end;
    bit to, hold, te, bz;
    logic [7:0] bt;
    logic [3:0] oh;
    logic [17:0] obs, expv;
    ifc.req_data     = data;
    ifc.req          = mask;
    ifc.latch_enable = 1'b0;
    w     = pick(mask, m_ptr);
    m_ptr = (w + 1) % N;
    bt    = data[8*w +: 8];
    oh    = 4'b0001 << w;
    @(negedge clk);
    obs  = {ifc.gnt, ifc.rx_en, ifc.synth_en, ifc.busy, ifc.timeout_err, ifc.rx_data, ifc.owner};
    expv = {oh, 1'b1, 1'b0, 1'b1, 1'b0, bt, 2'(w)};
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s grant: got %h required %h", name, obs, expv);
    end
    if (!keep) ifc.req = '0;
    to       = (d < 1 || d > T);
    last     = to ? T + G + 1 : d + H + G + 1;
    wait_end = to ? T : d;
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      hold = !to && t > d && t <= d + H;
      te   = to && t == T + 1;
      bz   = t < last;
      obs  = {ifc.gnt, ifc.rx_en, ifc.synth_en, ifc.busy, ifc.timeout_err, ifc.rx_data, ifc.owner};
      expv = {4'b0000, 1'b0, hold, bz, te, bt, 2'(w)};
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL %s cycle %0d: got %h required %h", name, t, obs, expv);
      end
      if (t == abort_t) begin
        rst              = 1'b1;
        ifc.req          = abort_req;
        ifc.latch_enable = 1'b0;
        return;
      end
      if (t <= wait_end)  ifc.latch_enable = !to && t == d;
      else if (t == last) ifc.latch_enable = 1'b0;
      else                ifc.latch_enable = noise ? 1'($urandom) : 1'b0;
      if (t == last)  ifc.req = keep ? mask : 4'b0000;
      else if (noise) ifc.req = 4'($urandom);
    end
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    rst               = 1'b1;
    ifc.req           = 4'b1111;
    ifc.req_data      = 32'hFFFF_FFFF;
    ifc.latch_enable  = 1'b1;
    ifc0.req          = 4'b0000;
    ifc0.req_data     = 32'h1122_3344;
    ifc0.latch_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    obs = {ifc.gnt, ifc.rx_en, ifc.synth_en, ifc.busy, ifc.timeout_err, ifc.rx_data, ifc.owner};
    checks++;
    if (obs !== 18'h0) begin
      failures++;
      $display("FAIL reset: got %h required %h", obs, 18'h0);
    end
    obs = {ifc0.gnt, ifc0.rx_en, ifc0.synth_en, ifc0.busy, ifc0.timeout_err, ifc0.rx_data, ifc0.owner};
    checks++;
    if (obs !== 18'h0) begin
      failures++;
      $display("FAIL reset_gap0: got %h required %h", obs, 18'h0);
    end
    rst              = 1'b0;
    ifc.req          = '0;
    ifc.latch_enable = 1'b0;
    m_ptr            = 0;
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 5; k++)
      xfer(4'b1111, 1'b1, $urandom_range(1, T), 1'b0, $urandom, 0, 4'b0, "round_robin");
  endtask

  task automatic test_single();
    logic [31:0] dv;
    dv = $urandom;
    dv[23:16] = 8'hA5;
    xfer(4'b0100, 1'b0, 1, 1'b0, dv, 0, 4'b0, "single");
  endtask

  task automatic test_timeout();
    xfer(4'($urandom_range(1, 15)), 1'b0, 0, 1'b0, $urandom, 0, 4'b0, "timeout");
  endtask

  task automatic test_collision();
    xfer(4'($urandom_range(1, 15)), 1'b0, T, 1'b0, $urandom, 0, 4'b0, "collision");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      xfer(4'($urandom_range(1, 15)), 1'b0, $urandom_range(0, T + 2), 1'b1, $urandom, 0, 4'b0,
           "random");
  endtask

  task automatic test_reset_mid_hold();
    logic [17:0] obs;
    xfer(4'b0100, 1'b0, 1, 1'b0, $urandom, 6, 4'b0010, "mid_hold");
    @(negedge clk);
    obs = {ifc.gnt, ifc.rx_en, ifc.synth_en, ifc.busy, ifc.timeout_err, ifc.rx_data, ifc.owner};
    checks++;
    if (obs !== 18'h0) begin
      failures++;
      $display("FAIL mid_hold_reset: got %h required %h", obs, 18'h0);
    end
    rst   = 1'b0;
    m_ptr = 0;
    xfer(4'b0010, 1'b0, 1, 1'b0, $urandom, 0, 4'b0, "after_reset");
  endtask

  task automatic test_reset_ptr();
    xfer(4'b0100, 1'b0, 1, 1'b0, $urandom, 0, 4'b0, "pre_ptr_reset");
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
    xfer(4'b1001, 1'b0, 1, 1'b0, $urandom, 0, 4'b0, "ptr_reset");
  endtask

  // GAP_CYCLES=0 build with ack tied high: next grant follows synth_en fall by one cycle.
  task automatic test_back_to_back_gap0();
    int n, w, p0;
    logic [31:0] dv;
    logic [14:0] obs, expv;
    p0 = 0;
    dv = 32'h1122_3344;
    ifc0.req_data = dv;
    ifc0.req      = 4'b0011;
    @(negedge clk);
    n = 0;
    while (ifc0.gnt === 4'b0000 && n < 5) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      w    = pick(4'b0011, p0);
      p0   = (w + 1) % N;
      obs  = {ifc0.gnt, ifc0.rx_en, ifc0.rx_data, ifc0.owner};
      expv = {4'(4'b0001 << w), 1'b1, dv[8*w +: 8], 2'(w)};
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL gap0 grant %0d: got %h required %h", k, obs, expv);
      end
      for (int t = 1; t <= H + 2; t++) begin
        @(negedge clk);
        checks++;
        if ({ifc0.gnt, ifc0.synth_en, ifc0.busy, ifc0.timeout_err} !==
            {4'b0000, (t >= 2 && t <= H + 1), (t <= H + 1), 1'b0}) begin
          failures++;
          $display("FAIL gap0 cycle %0d: got gnt=%b synth=%b busy=%b terr=%b", t,
                   ifc0.gnt, ifc0.synth_en, ifc0.busy, ifc0.timeout_err);
        end
      end
      @(negedge clk);
    end
    ifc0.req = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_collision();
    test_random();
    test_reset_mid_hold();
    test_reset_ptr();
    test_back_to_back_gap0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
